alu_cmd_issuer: RTL
===================

# alu_cmd_issuer

Sequential front end that drives the generated combinational 64-bit ALUs, which use opcodes ADD..XOR = 0..10 and a carry flag. It accepts tagged operation commands over a valid/ready interface and buffers them in a small FIFO. It presents each command's operands to the ALU, waits the required settle time, captures result and carry, and returns a tagged response over a second valid/ready interface. It sits between the command-generating agent/testbench layer and any ALU instance.

## Interface
- WIDTH, 64, operand/result width
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- MUL_WAIT, 2, extra EXEC cycles for MUL (opcode 7) to cover the multicycle multiplier path
- TAG_W, 4, command tag width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_opcode  in  4  ALU opcode
- cmd_a / cmd_b  in  WIDTH  operands (ALU input1/input2)
- cmd_shift  in  5  shift/rotate amount
- cmd_tag  in  TAG_W  returned unchanged with response
- alu_opcode  out  4  to ALU opcode
- alu_input1 / alu_input2  out  WIDTH  to ALU operands
- alu_shift  out  5  to ALU shiftValue
- alu_result  in  WIDTH  from ALU result
- alu_carry  in  1  from ALU carryFlag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts
- rsp_result  out  WIDTH  captured result
- rsp_carry  out  1  captured carry (ADD/SUB only, else 0)
- rsp_tag  out  TAG_W  tag of completed command
- rsp_err  out  1  illegal opcode (11–15)
- busy  out  1  FIFO non-empty or FSM not IDLE
- op_count  out  16  completed-response counter

## Operation
- FIFO: push on cmd_valid && cmd_ready; cmd_ready = !full. This is a pure function of full, so a same-cycle pop does not allow a push into a full FIFO. Pointers wrap modulo FIFO_DEPTH.
- Issue registers (opcode, a, b, shift, tag) drive alu_* directly and hold their value outside EXEC.
- FSM states IDLE, EXEC, RESP:
  - IDLE: when FIFO non-empty, pop into issue registers. Legal opcode → EXEC with wait_cnt = (opcode==7) ? MUL_WAIT : 0. Illegal opcode → RESP with rsp_result=0, rsp_carry=0, rsp_err=1.
  - EXEC: if wait_cnt≠0, decrement. Else capture alu_result into rsp_result. rsp_carry = alu_carry if opcode∈{0,1}, else 0. rsp_err=0. Go to RESP.
  - RESP: rsp_valid=1. rsp_* are stable until the handshake. On rsp_ready: op_count+1 (wraps 0xFFFF→0). If FIFO non-empty, pop and go directly to EXEC or RESP by the IDLE rules; else go to IDLE.
- rsp_tag always equals the tag of the command being responded to. Responses are returned in strict command order.
- Reset (async assert, any state, including mid-EXEC/RESP): FIFO flushed, in-flight command discarded, state IDLE. All outputs 0 except cmd_ready=1: rsp_valid, rsp_result, rsp_carry, rsp_tag, rsp_err, alu_*, busy, op_count are all 0.

## Timing
- Command accepted at edge E0. Popped at E1 (FSM idle). rsp_valid rises after E2 for non-MUL, after E2+MUL_WAIT for MUL, and after E1 for an illegal opcode.
- Back-to-back with rsp_ready held high: one response per 2 cycles for non-MUL. The RESP→EXEC pop saves the IDLE cycle.
- rsp_valid, once high, stays high with unchanged data until rsp_ready is sampled high.
- The ALU path is treated as single-cycle except MUL, which gets 1+MUL_WAIT cycles between issue and capture.

## Test plan
- Reset then ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1, tag=3 → rsp_result=0, rsp_carry=1, rsp_tag=3, rsp_err=0, rsp_valid 2 cycles after acceptance, op_count=1.
- MUL a=0x1_0000_0000, b=3 with MUL_WAIT=2 → rsp_result=0x3_0000_0000, rsp_carry=0, rsp_valid 4 cycles after acceptance.
- Hold rsp_ready=0 and push 5 commands (AND, OR, XOR, SUB, PASSB) → cmd_ready low after 4 FIFO pushes plus 1 in flight. Release rsp_ready → five in-order responses with correct tags; SUB 5−7 gives 0xFFFF_FFFF_FFFF_FFFE.
- Opcode 12, tag=9 → response 1 cycle after pop with rsp_err=1, rsp_result=0, rsp_tag=9; the following legal command is unaffected.
- Assert rst_n low while in EXEC for a MUL with 2 commands queued → after release, no response appears, busy=0, op_count=0, cmd_ready=1.
- Preload op_count to 0xFFFF via 65535 responses (or force) → next response makes op_count=0.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer
// Description : Sequential front end for a combinational 64-bit ALU. Buffers
//               tagged commands in a FIFO, issues them to the ALU, waits the
//               settle time (longer for MUL), captures result/carry and
//               returns an in-order tagged response over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer #(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int MUL_WAIT   = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // command interface
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [4:0]       cmd_shift,
  input  logic [TAG_W-1:0] cmd_tag,
  // ALU interface
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shift,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  // response interface
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  // status
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = (MUL_WAIT > 0) ? $clog2(MUL_WAIT + 1) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_LAST = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shift;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  // FIFO state
  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  cmd_t          head;
  logic          head_legal;

  // FSM and issue registers
  state_t           state_q;
  state_t           state_d;
  logic [WW-1:0]    wait_cnt;
  logic [3:0]       issue_opcode;
  logic [WIDTH-1:0] issue_a;
  logic [WIDTH-1:0] issue_b;
  logic [4:0]       issue_shift;
  logic [TAG_W-1:0] issue_tag;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  // Ready depends on full only, so a same-cycle pop never frees a slot early.
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign head       = mem[rd_ptr];
  assign head_legal = (head.opcode <= OP_LAST);

  // FIFO storage; flushing is done through the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{opcode: cmd_opcode, a: cmd_a, b: cmd_b,
                       shift: cmd_shift, tag: cmd_tag};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and pop decision; RESP pops directly to skip the IDLE cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = head_legal ? S_EXEC : S_RESP;
        end
      end
      S_EXEC: begin
        if (wait_cnt == '0) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = head_legal ? S_EXEC : S_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Issue registers, settle counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_opcode <= '0;
      issue_a      <= '0;
      issue_b      <= '0;
      issue_shift  <= '0;
      issue_tag    <= '0;
      wait_cnt     <= '0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_err      <= 1'b0;
    end else if (pop) begin
      issue_opcode <= head.opcode;
      issue_a      <= head.a;
      issue_b      <= head.b;
      issue_shift  <= head.shift;
      issue_tag    <= head.tag;
      wait_cnt     <= (head.opcode == OP_MUL) ? WW'(MUL_WAIT) : '0;
      if (!head_legal) begin
        // Illegal opcodes never touch the ALU and answer immediately.
        rsp_result <= '0;
        rsp_carry  <= 1'b0;
        rsp_err    <= 1'b1;
      end
    end else if (state_q == S_EXEC) begin
      if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WW'(1);
      end else begin
        rsp_result <= alu_result;
        rsp_carry  <= ((issue_opcode == OP_ADD) || (issue_opcode == OP_SUB)) ? alu_carry : 1'b0;
        rsp_err    <= 1'b0;
      end
    end
  end

  // Completed-response counter, wraps at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           op_count <= '0;
    else if (state_q == S_RESP && rsp_ready) op_count <= op_count + 16'd1;
  end

  assign alu_opcode = issue_opcode;
  assign alu_input1 = issue_a;
  assign alu_input2 = issue_b;
  assign alu_shift  = issue_shift;
  assign rsp_tag    = issue_tag;
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = !empty || (state_q != S_IDLE);

endmodule
`default_nettype wire
